hls_ip_job_sequencer: RTL
=========================

// Module: hls_ip_job_sequencer
// PURPOSE
// - Multi-engine ap_ctrl job sequencer between the HWPE control wrapper and N HLS engines.
// - Issues job_count_i ap_start/ap_ready handshakes per engine and counts ap_done completions.
// - Emits a done pulse per engine and drives the per-core event lines evt_o.
// - evt_o is a registered, mode-selectable merge of control-wrapper events and engine-done events.
// PARAMETERS
// N_CORES     2   cores receiving events
// N_EVT       2   event lines per core (REGFILE_N_EVT)
// N_ENGINES   2   HLS engines sequenced independently
// CNT_W       16  job counter width
// TIMEOUT     4096  watchdog limit in cycles (used only with HLS_SEQ_WATCHDOG_EN)
// PORTS
// clk_i         in   1                   clock
// rst_ni        in   1                   asynchronous active-low reset
// clear_i       in   1                   synchronous soft clear
// start_i       in   N_ENGINES           per-engine start pulse
// job_count_i   in   N_ENGINES*CNT_W     jobs to issue; sampled when start is accepted
// evt_mode_i    in   2                   00 ctrl, 01 engine, 10 ctrl|engine, 11 none
// evt_ctrl_i    in   N_CORES*N_EVT       events from control wrapper
// ap_start_o    out  N_ENGINES           HLS ap_start
// ap_ready_i    in   N_ENGINES           HLS ap_ready (accepts one job)
// ap_done_i     in   N_ENGINES           HLS ap_done (one job finished)
// busy_o        out  N_ENGINES           engine state != IDLE
// done_o        out  N_ENGINES           one-cycle pulse, all jobs finished
// err_o         out  N_ENGINES           sticky: unexpected ap_done or watchdog abort
// evt_o         out  N_CORES*N_EVT       registered event lines to cores
// BEHAVIOUR
// - Reset (rst_ni=0): all FSMs IDLE; counters 0; all outputs 0.
// - clear_i: same as reset, one cycle later; it overrides start_i in the same cycle.
// - Per-engine FSM:
//   - IDLE -> RUN on start_i when job_count != 0.
//     - Loads issue_left and done_left with job_count.
//   - IDLE -> DONE on start_i when job_count == 0; no handshake is issued.
//   - RUN:
//     - ap_start_o = (issue_left != 0).
//     - ap_start_o & ap_ready_i decrements issue_left.
//     - ap_done_i decrements done_left.
//     - Both may occur in the same cycle.
//   - RUN -> DONE when done_left reaches 0.
//   - DONE: done_o=1 for exactly one cycle, then IDLE.
// - start_i is ignored while not IDLE.
// - ap_done_i with done_left==0, or in IDLE: ignored, counters unchanged, err_o set.
// - ap_done_i on the ap_ready_i cycle of the last job is legal.
// - Counters never wrap; the decrement is gated at 0.
// - Latency:
//   - ap_start_o rises the cycle after start_i.
//   - done_o rises the cycle after the final ap_done_i.
// - Events:
//   - eng_evt[c][k] = OR of done_o[e] for all e with e % N_EVT == k; broadcast to every core c.
//   - evt_o is registered (1 cycle) from the mode-selected term; 11 forces 0.
//   - evt_mode_i may change at any time and takes effect on the next evt_o register update.
// - err_o is cleared only by rst_ni or clear_i.
// CONFIGURATION
// - HLS_SEQ_WATCHDOG_EN defined:
//   - Per-engine idle counter runs in RUN and resets on any ap_ready_i or ap_done_i.
//   - Counter reaching TIMEOUT: ap_start_o drops, FSM goes straight to IDLE, err_o sets, no done_o.
// - Not defined: no counter; err_o is set only by unexpected ap_done_i.
// TESTING
// - Reset, then job_count=3 on engine 0, ap_ready 1 cycle after each ap_start ->
//   3 ready handshakes, 3 ap_done, done_o[0] one cycle, evt_o[*][0]=1 one cycle later (mode 01).
// - start_i[1] with job_count=0 -> done_o[1] pulse next cycle, ap_start_o[1] never high.
// - ap_done_i[0] while IDLE -> err_o[0]=1 and stays until clear_i; state stays IDLE.
// - Both engines run 2 jobs concurrently, done_o in the same cycle, mode 10 with evt_ctrl_i=0b01 per core ->
//   evt_o per core = 0b11.
// - clear_i asserted mid-RUN (issue_left=1) -> next cycle ap_start_o=0, busy_o=0, no done_o.
// - With HLS_SEQ_WATCHDOG_EN, TIMEOUT=16, ap_ready never asserted ->
//   after 16 cycles in RUN, err_o=1, busy_o=0, no done_o.

Source files
------------

// File: rtl/hls_ip_job_sequencer_if.sv
// ap_ctrl handshake bundle between the job sequencer (master) and its HLS engines (slave).
// Signal names are those seen from the sequencer side.
interface hls_ip_job_sequencer_if #(
    parameter int N_ENGINES = 2
);
    logic [N_ENGINES-1:0] ap_start_o;
    logic [N_ENGINES-1:0] ap_ready_i;
    logic [N_ENGINES-1:0] ap_done_i;

    modport master (
        output ap_start_o,
        input  ap_ready_i,
        input  ap_done_i
    );

    modport slave (
        input  ap_start_o,
        output ap_ready_i,
        output ap_done_i
    );
endinterface

// File: rtl/hls_ip_job_sequencer.sv
// Multi-engine ap_ctrl job sequencer: issues job_count ap_start/ap_ready handshakes per
// engine, counts ap_done completions, pulses done_o and drives registered per-core events.
// Optional feature macro: HLS_SEQ_WATCHDOG_EN (per-engine inactivity abort after TIMEOUT cycles).
module hls_ip_job_sequencer #(
    parameter int N_CORES   = 2,
    parameter int N_EVT     = 2,
    parameter int N_ENGINES = 2,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [N_ENGINES-1:0]         start_i,
    input  logic [N_ENGINES*CNT_W-1:0]   job_count_i,
    input  logic [1:0]                   evt_mode_i,
    input  logic [N_CORES*N_EVT-1:0]     evt_ctrl_i,
    hls_ip_job_sequencer_if.master       ap_if,
    output logic [N_ENGINES-1:0]         busy_o,
    output logic [N_ENGINES-1:0]         done_o,
    output logic [N_ENGINES-1:0]         err_o,
    output logic [N_CORES*N_EVT-1:0]     evt_o
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // Counters stop at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    state_e               state_q [N_ENGINES];
    state_e               state_d [N_ENGINES];
    logic [CNT_W-1:0]     issue_q [N_ENGINES];
    logic [CNT_W-1:0]     issue_d [N_ENGINES];
    logic [CNT_W-1:0]     dleft_q [N_ENGINES];
    logic [CNT_W-1:0]     dleft_d [N_ENGINES];
    logic [N_ENGINES-1:0] ap_start_q, ap_start_d;
    logic [N_ENGINES-1:0] busy_q, busy_d;
    logic [N_ENGINES-1:0] done_q, done_d;
    logic [N_ENGINES-1:0] err_q, err_d;
    logic [N_CORES*N_EVT-1:0] eng_evt, evt_sel, evt_q;

`ifdef HLS_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q [N_ENGINES];
    logic [WD_W-1:0] wd_d [N_ENGINES];
`endif

    // Per-engine next state; registered outputs are derived from the next state so they
    // line up with the state they describe.
    always_comb begin
        for (int e = 0; e < N_ENGINES; e++) begin
            state_d[e] = state_q[e];
            issue_d[e] = issue_q[e];
            dleft_d[e] = dleft_q[e];
            err_d[e]   = err_q[e];
`ifdef HLS_SEQ_WATCHDOG_EN
            wd_d[e]    = '0;
`endif
            case (state_q[e])
                S_IDLE: begin
                    if (ap_if.ap_done_i[e]) err_d[e] = 1'b1;
                    if (start_i[e]) begin
                        issue_d[e] = job_count_i[e*CNT_W +: CNT_W];
                        dleft_d[e] = job_count_i[e*CNT_W +: CNT_W];
                        state_d[e] = (job_count_i[e*CNT_W +: CNT_W] == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (ap_start_q[e] && ap_if.ap_ready_i[e]) issue_d[e] = dec_sat(issue_q[e]);
                    if (ap_if.ap_done_i[e]) begin
                        if (dleft_q[e] == '0) err_d[e] = 1'b1;
                        else                  dleft_d[e] = dec_sat(dleft_q[e]);
                    end
                    if (dleft_d[e] == '0) state_d[e] = S_DONE;
`ifdef HLS_SEQ_WATCHDOG_EN
                    // Any handshake activity restarts the inactivity window.
                    if (!(ap_if.ap_ready_i[e] || ap_if.ap_done_i[e])) wd_d[e] = wd_q[e] + 1'b1;
                    if (wd_d[e] >= WD_W'(TIMEOUT)) begin
                        state_d[e] = S_IDLE;
                        issue_d[e] = '0;
                        dleft_d[e] = '0;
                        err_d[e]   = 1'b1;
                        wd_d[e]    = '0;
                    end
`endif
                end
                default: begin
                    if (ap_if.ap_done_i[e]) err_d[e] = 1'b1;
                    state_d[e] = S_IDLE;
                end
            endcase
            ap_start_d[e] = (state_d[e] == S_RUN) && (issue_d[e] != '0);
            busy_d[e]     = (state_d[e] != S_IDLE);
            done_d[e]     = (state_d[e] == S_DONE);
        end
    end

    // Engine-done events fold onto line e % N_EVT and are broadcast to every core.
    always_comb begin
        eng_evt = '0;
        for (int c = 0; c < N_CORES; c++) begin
            for (int e = 0; e < N_ENGINES; e++) begin
                eng_evt[c*N_EVT + (e % N_EVT)] = eng_evt[c*N_EVT + (e % N_EVT)] | done_q[e];
            end
        end
        case (evt_mode_i)
            2'b00:   evt_sel = evt_ctrl_i;
            2'b01:   evt_sel = eng_evt;
            2'b10:   evt_sel = evt_ctrl_i | eng_evt;
            default: evt_sel = '0;
        endcase
    end

    // State, counters and registered outputs; clear_i behaves as a synchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < N_ENGINES; e++) begin
                state_q[e] <= S_IDLE;
                issue_q[e] <= '0;
                dleft_q[e] <= '0;
`ifdef HLS_SEQ_WATCHDOG_EN
                wd_q[e]    <= '0;
`endif
            end
            ap_start_q <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
            evt_q      <= '0;
        end else if (clear_i) begin
            for (int e = 0; e < N_ENGINES; e++) begin
                state_q[e] <= S_IDLE;
                issue_q[e] <= '0;
                dleft_q[e] <= '0;
`ifdef HLS_SEQ_WATCHDOG_EN
                wd_q[e]    <= '0;
`endif
            end
            ap_start_q <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
            evt_q      <= '0;
        end else begin
            for (int e = 0; e < N_ENGINES; e++) begin
                state_q[e] <= state_d[e];
                issue_q[e] <= issue_d[e];
                dleft_q[e] <= dleft_d[e];
`ifdef HLS_SEQ_WATCHDOG_EN
                wd_q[e]    <= wd_d[e];
`endif
            end
            ap_start_q <= ap_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            evt_q      <= evt_sel;
        end
    end

    assign ap_if.ap_start_o = ap_start_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign evt_o            = evt_q;

endmodule
